// File: rtl/arith_pkg.sv
// Shared types and constants for the arbitrated saturating arithmetic unit.
package arith_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [SEL_W-1:0] OP_ADD    = 2'b00;
   localparam logic [SEL_W-1:0] OP_PADDSB = 2'b01;
   localparam logic [SEL_W-1:0] OP_SUB    = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the requester that was
// not granted last time wins.
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic gnt0,
   output logic gnt1,
   output logic gnt_id
);

   always_comb begin
      gnt0   = valid0 & (~valid1 | last_grant);
      gnt1   = valid1 & (~valid0 | ~last_grant);
      gnt_id = gnt1;
   end

endmodule

// File: rtl/arith_arbiter.sv
// Round-robin front end sharing one combinational arithmetic unit between two
// requesters: grant, execute for one cycle, then hold the tagged response.
module arith_arbiter #(
   parameter int unsigned DATA_W = arith_pkg::DATA_W,
   parameter int unsigned SEL_W  = arith_pkg::SEL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [SEL_W-1:0]  req0_sel,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [SEL_W-1:0]  req1_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_v,
   input  logic              alu_n,
   input  logic              alu_z,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_v,
   output logic              rsp_n,
   output logic              rsp_z
);

   import arith_pkg::*;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              pend_id_q, pend_id_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_v_q, rsp_v_d;
   logic              rsp_n_q, rsp_n_d;
   logic              rsp_z_q, rsp_z_d;

   logic gnt0, gnt1, gnt_id;
   logic idle;

   rr_arb2 u_rr_arb2 (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant_q),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .gnt_id     (gnt_id)
   );

   assign idle = (state_q == ST_IDLE);

   // Gated by rst_n so every output reads 0 while reset is held.
   assign req0_ready = rst_n & idle & gnt0;
   assign req1_ready = rst_n & idle & gnt1;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      pend_id_d    = pend_id_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_v_d      = rsp_v_q;
      rsp_n_d      = rsp_n_q;
      rsp_z_d      = rsp_z_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt0 || gnt1) begin
               alu_a_d      = gnt1 ? req1_a   : req0_a;
               alu_b_d      = gnt1 ? req1_b   : req0_b;
               alu_sel_d    = gnt1 ? req1_sel : req0_sel;
               pend_id_d    = gnt_id;
               last_grant_d = gnt_id;
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_data_d  = alu_out;
            rsp_v_d     = alu_v;
            rsp_n_d     = alu_n;
            rsp_z_d     = alu_z;
            rsp_id_d    = pend_id_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         pend_id_q    <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_v_q      <= 1'b0;
         rsp_n_q      <= 1'b0;
         rsp_z_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         pend_id_q    <= pend_id_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_v_q      <= rsp_v_d;
         rsp_n_q      <= rsp_n_d;
         rsp_z_q      <= rsp_z_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_v     = rsp_v_q;
   assign rsp_n     = rsp_n_q;
   assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_arith_arbiter.sv
// Directed bench for arith_arbiter with a behavioural saturating arithmetic unit.
module tb_arith_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]  req0_sel, req1_sel;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [1:0]  alu_sel;
   logic        alu_v, alu_n, alu_z;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_v, rsp_n, rsp_z;
   logic [15:0] rsp_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   arith_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sel   (req0_sel),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sel   (req1_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .alu_v      (alu_v),
      .alu_n      (alu_n),
      .alu_z      (alu_z),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_v      (rsp_v),
      .rsp_n      (rsp_n),
      .rsp_z      (rsp_z)
   );

   // Saturating unit: sel[0] packed signed-byte add, else sel[1] subtract, else add.
   always_comb begin
      logic [15:0] s;
      logic [7:0]  hi, lo;
      logic        ov_hi, ov_lo;
      s     = '0;
      hi    = '0;
      lo    = '0;
      ov_hi = 1'b0;
      ov_lo = 1'b0;
      alu_v = 1'b0;
      if (alu_sel[0]) begin
         hi    = alu_a[15:8] + alu_b[15:8];
         lo    = alu_a[7:0] + alu_b[7:0];
         ov_hi = (alu_a[15] == alu_b[15]) && (hi[7] != alu_a[15]);
         ov_lo = (alu_a[7] == alu_b[7]) && (lo[7] != alu_a[7]);
         if (ov_hi) hi = alu_a[15] ? 8'h80 : 8'h7F;
         if (ov_lo) lo = alu_a[7] ? 8'h80 : 8'h7F;
         s     = {hi, lo};
         alu_v = ov_hi | ov_lo;
      end else if (alu_sel[1]) begin
         s     = alu_a - alu_b;
         alu_v = (alu_a[15] != alu_b[15]) && (s[15] != alu_a[15]);
         if (alu_v) s = alu_a[15] ? 16'h8000 : 16'h7FFF;
      end else begin
         s     = alu_a + alu_b;
         alu_v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
         if (alu_v) s = alu_a[15] ? 16'h8000 : 16'h7FFF;
      end
      alu_out = s;
      alu_n   = s[15];
      alu_z   = (s == 16'h0000);
   end

   typedef struct {
      logic        v0;
      logic [15:0] a0, b0;
      logic [1:0]  s0;
      logic        v1;
      logic [15:0] a1, b1;
      logic [1:0]  s1;
      logic        id;
      logic [15:0] data;
      logic        fv, fn, fz;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Call away from a rising edge with requester inputs already driven.
   task automatic expect_op(input logic id, input logic [15:0] d, input logic fv,
                            input logic fn, input logic fz, input bit mutate);
      int n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!(req0_ready || req1_ready)) begin
         n_checks++;
         n_fail++;
         $display("FAIL grant_timeout: got no ready expected ready for id %0d", id);
         return;
      end
      check("grant", {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
      @(posedge clk);
      #1;
      if (mutate) req0_a = 16'hFFFF;
      @(negedge clk);
      check("exec_quiet", {29'd0, rsp_valid, req1_ready, req0_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("resp", {11'd0, rsp_valid, rsp_id, rsp_data, rsp_v, rsp_n, rsp_z},
            {11'd0, 1'b1, id, d, fv, fn, fz});
      check("resp_quiet", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // v0 a0 b0 s0 | v1 a1 b1 s1 | id data v n z
      vecs[0] = '{1'b1, 16'h0003, 16'h0004, 2'b00, 1'b0, 16'h0000, 16'h0000, 2'b00,
                  1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h8000, 16'h0001, 2'b10,
                  1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 16'h1234, 16'h1111, 2'b00, 1'b1, 16'h5555, 16'h1111, 2'b10,
                  1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 16'h0001, 16'h0001, 2'b00, 1'b1, 16'h7F01, 16'h0180, 2'b01,
                  1'b1, 16'h7F81, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 16'h0003, 16'h0005, 2'b10, 1'b0, 16'h0000, 16'h0000, 2'b00,
                  1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'hFFFF, 16'h0001, 2'b00,
                  1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};

      req0_a = '0; req0_b = '0; req0_sel = '0;
      req1_a = '0; req1_b = '0; req1_sel = '0;
      rst_n  = 1'b1;
      #2;
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready  = 1'b1;
      #1;
      check("reset_outputs", {alu_a, alu_b[15:5]}, 32'd0);
      check("reset_outputs2", {alu_b[4:0], alu_sel, rsp_valid, rsp_id, rsp_data, rsp_v, rsp_n,
                               rsp_z, req0_ready, req1_ready}, 32'd0);
      do_reset();

      // Table: arbitration and arithmetic pass-through, starting from reset.
      for (int i = 0; i < 6; i++) begin
         req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_sel = vecs[i].s0;
         req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_sel = vecs[i].s1;
         expect_op(vecs[i].id, vecs[i].data, vecs[i].fv, vecs[i].fn, vecs[i].fz, 1'b0);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end

      // Tie after reset: req0 first, then req1.
      do_reset();
      req0_valid = 1'b1; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_sel = 2'b00;
      req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0005; req1_sel = 2'b10;
      expect_op(1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
      req0_valid = 1'b0;
      expect_op(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      req1_valid = 1'b0;

      // Sustained contention alternates grants.
      req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_sel = 2'b00;
      req1_valid = 1'b1; req1_a = 16'h000A; req1_b = 16'h0003; req1_sel = 2'b10;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) expect_op(1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
         else            expect_op(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Backpressure: response held while req1 waits.
      rsp_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0001; req0_sel = 2'b00;
      #1;
      check("bp_grant0", {31'd0, req0_ready}, 32'd1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0003; req1_sel = 2'b10;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold", {11'd0, rsp_valid, rsp_id, rsp_data, rsp_v, rsp_n, rsp_z},
               {11'd0, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0});
         check("bp_no_ready", {31'd0, req1_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release", {30'd0, rsp_valid, req1_ready}, 32'd1);
      expect_op(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
      req1_valid = 1'b0;

      // Operand changes after the handshake must not reach the result.
      req0_valid = 1'b1; req0_a = 16'h0010; req0_b = 16'h0020; req0_sel = 2'b00;
      expect_op(1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b1);
      req0_valid = 1'b0;
      check("alu_a_held", {16'd0, alu_a}, 32'h0000_0010);

      // Reset during EXEC clears everything; req0 then wins the tie.
      req0_valid = 1'b1; req0_a = 16'h00AA; req0_b = 16'h0001; req0_sel = 2'b00;
      req1_valid = 1'b1; req1_a = 16'h0009; req1_b = 16'h0001; req1_sel = 2'b00;
      #1;
      check("pre_abort_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {alu_a, alu_b[15:5]}, 32'd0);
      check("abort_outputs2", {alu_b[4:0], alu_sel, rsp_valid, rsp_id, rsp_data, rsp_v, rsp_n,
                               rsp_z, req0_ready, req1_ready}, 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      expect_op(1'b0, 16'h00AB, 1'b0, 1'b0, 1'b0, 1'b0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
